muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle multiply/divide unit that owns the architectural HI/LO registers of the three-stage pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU from the execute stage, runs a radix-2 iterative shift-add multiply or restoring divide over WIDTH cycles, and commits the result to HI/LO. It services MTHI/MTLO writes and raises a stall to the pipeline when MFHI/MFLO is issued while an operation is in flight. It replaces the single-cycle combinational multiply path in the ALU.

## Interface
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset (sampled on clk rising edge)
- start  in  1  request a new operation; sampled only in IDLE
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- rd_req  in  1  MFHI or MFLO present in execute stage
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- busy  out  1  operation in flight (registered)
- done  out  1  one-cycle pulse: HI/LO just committed
- div_by_zero  out  1  one-cycle pulse with done when DIV/DIVU had b==0
- stall  out  1  combinational busy & rd_req

## Operation
- States: IDLE, CALC, FIX.
- IDLE: start=1 captures op, magnitudes |a|,|b| for signed ops (raw for unsigned), result signs (quotient/product sign = a[W-1]^b[W-1], remainder sign = a[W-1]), count=0; → CALC; busy=1.
- CALC: one iteration per cycle; multiply = shift-add on 2·WIDTH accumulator; divide = restoring subtract on {remainder, quotient}. count increments; at count==WIDTH-1 → FIX.
- FIX: apply two's-complement negation where required, write HI/LO (multiply: HI=upper, LO=lower; divide: LO=quotient, HI=remainder), pulse done, → IDLE, busy=0.
- Signed divide truncates toward zero; remainder takes dividend sign.
- Overflow 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0.
- Divide by zero (either DIV or DIVU): same latency; HI=original a, LO=all ones, div_by_zero=1 with done.
- hi_we/lo_we: write wdata at the edge when in IDLE; ignored in CALC/FIX. In IDLE with start=1 the write is applied and later overwritten by the result.
- start while not IDLE: ignored; the pipeline must hold it via stall/decode interlock.
- rd_req while busy: stall=1 until the cycle after done; the pipeline re-samples hi/lo then.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, count=0. Mid-operation reset abandons the operation; no partial HI/LO update.
- Edge E0: start accepted. busy=1 from E0 until E(WIDTH+1).
- Edges E1..E(WIDTH): iterations.
- Edge E(WIDTH+1): HI/LO updated, done=1 and busy=0 for the following cycle. Total latency is WIDTH+1 edges after acceptance, which is 33 for WIDTH=32.
- Back-to-back: start may be accepted at the same cycle done is high (state already IDLE).
- stall has zero-cycle latency from rd_req; it never depends on start in the same cycle.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF → busy for 33 cycles; hi=0xFFFFFFFE, lo=0x00000001, done pulse exactly once.
- MULT a=0xFFFFFFFD (−3) b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV a=−7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x1234 b=0 → after 33 cycles hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1 coincident with done. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Start DIVU 100/7, assert rd_req at cycle 5 and hold → stall=1 until done, then hi=2, lo=14. hi_we during busy → ignored.
- In IDLE: lo_we wdata=0xCAFEF00D → lo updates next cycle. A second start while busy → ignored, with a single done.
- Start MULT, drop rst_n for one edge at cycle 10 → hi=lo=0, busy=0, no done. A new MULTU 3×4 then completes with lo=12.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO registers: radix-2 shift-add
// multiply and restoring divide over WIDTH cycles, with MTHI/MTLO and MFHI/MFLO stall.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             stall,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;       // multiply: {product hi, multiplier/product lo}; divide: {rem, quo}
  logic [WIDTH-1:0]   opnd;      // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   a_orig;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               b_zero;

  logic               signed_op;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign stall     = busy & rd_req;
  assign state_dbg = state;

  always_comb begin
    signed_op = ~op[0];
    mag_a     = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mag_b     = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;

    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    mul_next  = {mul_sum, acc[WIDTH-1:1]};

    // A borrow out of the trial subtraction means the shifted remainder is kept.
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_trial = div_shift - {1'b0, opnd};
    div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    prod = neg_q ? (~acc + 1'b1) : acc;
    quo  = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (count == CW'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      acc         <= '0;
      opnd        <= '0;
      a_orig      <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      b_zero      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_next;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div <= op[1];
            neg_q  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= signed_op & a[WIDTH-1];
            b_zero <= (b == '0);
            a_orig <= a;
            count  <= '0;
            busy   <= 1'b1;
            if (op[1]) begin
              acc  <= {{WIDTH{1'b0}}, mag_a};
              opnd <= mag_b;
            end else begin
              acc  <= {{WIDTH{1'b0}}, mag_b};
              opnd <= mag_a;
            end
          end
        end
        CALC: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + 1'b1;
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (!is_div) begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end else if (b_zero) begin
            hi          <= a_orig;
            lo          <= {WIDTH{1'b1}};
            div_by_zero <= 1'b1;
          end else begin
            hi <= rem;
            lo <= quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed corner cases plus random
// operations checked against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        rd_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic        stall;
  logic [1:0]  state_dbg;

  logic [64:0] exp_q[$];   // {div_by_zero, hi, lo}
  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .rd_req(rd_req),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .stall(stall), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          ps;
    longint unsigned pu;
    int              xs, ys;
    logic [31:0]     q, r;
    xs = x;
    ys = y;
    case (o)
      2'b00: begin ps = longint'(xs) * longint'(ys); return {1'b0, ps[63:0]}; end
      2'b01: begin pu = {32'b0, x} * {32'b0, y}; return {1'b0, pu[63:0]}; end
      default: begin
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
          q = xs / ys;
          r = xs % ys;
        end else begin
          q = x / y;
          r = x % y;
        end
        return {1'b0, r, q};
      end
    endcase
  endfunction

  // driver tasks
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit push, input bit rnd_wr);
    int guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      n_cmp++; n_fail++;
      $display("FAIL issue_wait: busy=%b expected 0 within 200 cycles", busy);
    end
    start = 1'b1; op = o; a = x; b = y;
    if (rnd_wr) begin
      hi_we = 1'($urandom_range(0, 1));
      lo_we = 1'($urandom_range(0, 1));
      wdata = $urandom;
    end
    if (push) exp_q.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (busy && guard < 100);
    if (busy) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_idle: busy=%b expected 0 within 100 cycles", busy);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_done: hi=%h lo=%h with nothing expected", hi, lo);
      end else begin
        check("result", {div_by_zero, hi, lo}, exp_q.pop_front());
      end
    end
    if (rst_n && div_by_zero && !done) begin
      n_cmp++; n_fail++;
      $display("FAIL dbz_alone: div_by_zero=1 done=0 expected done=1");
    end
  end

  initial begin
    int cnt;
    int bad;
    int d0;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; rd_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {busy, done, div_by_zero, stall, hi, lo}, {4'b0, 64'd0});
    rst_n = 1'b1;
    @(negedge clk);

    // busy window and single done for MULTU max*max
    d0 = done_cnt;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    cnt = 0;
    do begin
      @(negedge clk);
      if (busy) cnt++;
    end while (busy && cnt < 100);
    check("busy_cycles", 65'(cnt), 65'd33);
    check("done_high_after_busy", {64'd0, done}, 65'd1);
    repeat (3) @(negedge clk);
    check("done_once", 65'(done_cnt - d0), 65'd1);

    issue(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);          wait_idle();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);          wait_idle();
    issue(2'b11, 32'h0000_1234, 32'd0, 1'b1, 1'b0);          wait_idle();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);  wait_idle();
    issue(2'b10, 32'h8000_0001, 32'd0, 1'b1, 1'b0);          wait_idle();

    // stall held while busy; MTHI during busy ignored
    issue(2'b11, 32'd100, 32'd7, 1'b1, 1'b0);
    bad = 0;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (i > 5 && stall !== 1'b1) bad++;
      if (i == 5) rd_req = 1'b1;
      if (i == 10) begin hi_we = 1'b1; wdata = 32'hDEAD_BEEF; end
      if (i == 11) hi_we = 1'b0;
    end
    check("stall_held", 65'(bad), 65'd0);
    @(negedge clk);
    check("stall_release", {63'd0, done, stall}, 65'b10);
    rd_req = 1'b0;

    // MTLO in idle
    lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo", {33'd0, lo}, {33'd0, 32'hCAFE_F00D});
    check("mthi_ignored_busy", {33'd0, hi}, {33'd0, 32'd2});

    // second start while busy is ignored
    d0 = done_cnt;
    issue(2'b01, 32'd6, 32'd7, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    check("single_done", 65'(done_cnt - d0), 65'd1);

    // reset mid-operation abandons it
    d0 = done_cnt;
    issue(2'b00, 32'd1234, 32'd5678, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_state", {busy, hi, lo}, 65'd0);
    repeat (40) @(negedge clk);
    check("midreset_no_done", 65'(done_cnt - d0), 65'd0);
    issue(2'b01, 32'd3, 32'd4, 1'b1, 1'b0);
    wait_idle();

    // random, back-to-back, with MTHI/MTLO coinciding with start
    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      issue(ro, ra, rb, 1'b1, 1'b1);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check("queue_drained", 65'(exp_q.size()), 65'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
